// File: rtl/cpsd_pkg.sv
// rtl/cpsd_pkg.sv - shared constants, width helper and symbol-entry layout for the CPSD symbol mapper
package cpsd_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int L_DEF          = 6;
  localparam int IDX_W_DEF      = 8;
  localparam int DEPTH_DEF      = 4;
  localparam int CNT_W_DEF      = 16;

  // FIFO entry layout is {idx, clamped}: clamp flag in bit 0, index above it
  localparam int ENTRY_CLAMP_BIT = 0;
  localparam int ENTRY_IDX_LSB   = 1;

  // Smallest w with 2**w >= n (returns 0 for n <= 1)
  function automatic int clog2w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  function automatic int entry_w(input int idx_w);
    return idx_w + 1;
  endfunction

endpackage

// File: rtl/cpsd_sync_fifo.sv
// rtl/cpsd_sync_fifo.sv - synchronous FIFO with wrap-bit pointers for buffered symbol entries
module cpsd_sync_fifo
  import cpsd_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [clog2w(DEPTH):0]    count
);

  localparam int AW = clog2w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             wr_en;
  logic             rd_en;

  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Same low bits with differing wrap bits means the writer has lapped the reader
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];

  // Storage is not reset; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wdata;
  end

  // Pointer update; pointers wrap naturally through the extra MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/cpsd_symbol_mapper.sv
// rtl/cpsd_symbol_mapper.sv - clamps quantized (vqx,vqy) pairs, maps to idx=vqx*L+vqy, buffers symbols; option macro CPSD_SYMBOL_MAPPER_CLAMP_CNT_EN
module cpsd_symbol_mapper
  import cpsd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int L          = L_DEF,
  parameter int IDX_W      = IDX_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] vqx,
  input  logic [DATA_WIDTH-1:0] vqy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_clamped,
  output logic [CNT_W-1:0]      sym_count,
  output logic [CNT_W-1:0]      clamp_count
);

  localparam int AW = clog2w(DEPTH);
  localparam int EW = entry_w(IDX_W);
  localparam logic signed [DATA_WIDTH-1:0] LMAX = DATA_WIDTH'(L - 1);

  logic [IDX_W-1:0] cx;
  logic [IDX_W-1:0] cy;
  logic             clx;
  logic             cly;
  logic [IDX_W-1:0] idx_c;
  logic             clamp_c;

  logic             s1_valid;
  logic [IDX_W-1:0] s1_idx;
  logic             s1_clamped;

  logic             accept;
  logic             push;
  logic             pop;
  logic [EW-1:0]    head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;

  // Signed clamp of each component into 0..L-1, then flatten the pair to one index
  always_comb begin
    cx  = '0;
    cy  = '0;
    clx = 1'b0;
    cly = 1'b0;
    if (vqx[DATA_WIDTH-1]) begin
      clx = 1'b1;
    end else if ($signed(vqx) > LMAX) begin
      cx  = IDX_W'(L - 1);
      clx = 1'b1;
    end else begin
      cx  = IDX_W'(vqx);
    end
    if (vqy[DATA_WIDTH-1]) begin
      cly = 1'b1;
    end else if ($signed(vqy) > LMAX) begin
      cy  = IDX_W'(L - 1);
      cly = 1'b1;
    end else begin
      cy  = IDX_W'(vqy);
    end
    idx_c   = IDX_W'(32'(cx) * 32'(L) + 32'(cy));
    clamp_c = clx | cly;
  end

  // Capacity counts the in-flight stage register so a FIFO write can never overflow
  assign in_ready  = !rst && en && !fifo_full &&
                     ((32'(fifo_count) + 32'(s1_valid)) < 32'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign push      = s1_valid && en;
  assign out_valid = !rst && en && !fifo_empty;
  assign pop       = out_valid && out_ready;

  assign out_idx     = fifo_empty ? '0   : head[ENTRY_IDX_LSB +: IDX_W];
  assign out_clamped = fifo_empty ? 1'b0 : head[ENTRY_CLAMP_BIT];

  // Stage 1 holds one mapped symbol; a new accept may overwrite it in the same cycle it drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_idx     <= '0;
      s1_clamped <= 1'b0;
    end else if (en) begin
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_idx     <= idx_c;
        s1_clamped <= clamp_c;
      end else if (push) begin
        s1_valid   <= 1'b0;
      end
    end
  end

  cpsd_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({s1_idx, s1_clamped}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Emitted-symbol counter, wraps modulo 2**CNT_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_count <= '0;
    end else if (pop) begin
      sym_count <= sym_count + CNT_W'(1);
    end
  end

`ifdef CPSD_SYMBOL_MAPPER_CLAMP_CNT_EN
  logic [CNT_W-1:0] clamp_cnt_q;

  // Clamp-event counter, counted at accept time and saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clamp_cnt_q <= '0;
    end else if (accept && clamp_c && (clamp_cnt_q != '1)) begin
      clamp_cnt_q <= clamp_cnt_q + CNT_W'(1);
    end
  end

  assign clamp_count = clamp_cnt_q;
`else
  assign clamp_count = '0;
`endif

endmodule
